// File: rtl/mem_port_sequencer.sv
// Arbitrates the shared RAM port between instruction fetch and LDR/STR data.
// Optional fetch starvation guard: define MEM_SEQ_STARVE_GUARD_EN.
module mem_port_sequencer #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rw_q, mem_rw_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_gnt_c, d_gnt_c;
  logic          force_if;

`ifdef MEM_SEQ_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  // Fetch overrides data once data has won STARVE_LIMIT times in a row.
  assign force_if = if_req && (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (if_gnt_c) begin
      starve_d = '0;
    end else if (d_gnt_c && if_req && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign force_if = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = mem_rw_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt_c    = 1'b0;
    d_gnt_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grants are gated by rst so every output reads 0 in reset.
        d_gnt_c  = rst && d_req && !force_if;
        if_gnt_c = rst && if_req && (!d_req || force_if);
        if (d_gnt_c) begin
          own_d_d     = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_rw_d    = d_we;
          cnt_d       = '0;
          state_d     = ACCESS;
        end else if (if_gnt_c) begin
          own_d_d     = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_rw_d    = 1'b0;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_rw_d    = 1'b0;
          if (own_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rw_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_c;
  assign d_gnt     = d_gnt_c;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign busy      = (state_q != IDLE);

endmodule
